// File: rtl/arb_pkg.sv
// ============================================================================
// Module      : arb_pkg
// Description : Shared owner IDs, FSM states and access-size codes for the
//               sram-like inst/data arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package arb_pkg;

    localparam logic OWN_INST = 1'b0;
    localparam logic OWN_DATA = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOCK_D = 2'd1,
        LOCK_I = 2'd2
    } arb_state_t;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

`default_nettype wire

// File: rtl/arb_order_fifo.sv
// ============================================================================
// Module      : arb_order_fifo
// Description : Small FIFO of 1-bit owner IDs recording the order in which
//               requests were accepted, so responses return to their owner.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module arb_order_fifo #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic resetn,
    input  logic i_push,
    input  logic i_push_id,
    input  logic i_pop,
    output logic o_full,
    output logic o_empty,
    output logic o_head
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_do_push;
    logic w_do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1))
            return '0;
        return p + PTR_W'(1);
    endfunction

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_head    = r_mem[r_rd_ptr];
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;

    // Payload storage needs no reset: only entries below r_count are read.
    always_ff @(posedge clk) begin
        if (w_do_push)
            r_mem[r_wr_ptr] <= i_push_id;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push)
                r_wr_ptr <= next_ptr(r_wr_ptr);
            if (w_do_pop)
                r_rd_ptr <= next_ptr(r_rd_ptr);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/sram_like_arbiter.sv
// ============================================================================
// Module      : sram_like_arbiter
// Description : Shares one sram-like port between inst and data masters with
//               locked grants, data priority and an inst starvation guard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_like_arbiter
    import arb_pkg::*;
#(
    parameter int OUTSTANDING  = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [3:0]  inst_wstrb,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata,
    output logic        arb_err
);

    localparam int STV_W = $clog2(STARVE_LIMIT + 1);

    arb_state_t       r_state;
    arb_state_t       w_state_nxt;
    logic [STV_W-1:0] r_starve;
    logic             r_err;

    logic w_full;
    logic w_empty;
    logic w_head;
    logic w_sel_valid;
    logic w_sel;
    logic w_accept;
    logic w_pop;
    logic w_starved;

    assign w_starved = (r_starve == STV_W'(STARVE_LIMIT));

    // Grant selection and request mux; w_full is registered, so mem_data_ok
    // never reaches mem_req combinationally.
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel       = OWN_INST;
        if (!w_full) begin
            case (r_state)
                IDLE: begin
                    if (data_req && !(w_starved && inst_req)) begin
                        w_sel_valid = 1'b1;
                        w_sel       = OWN_DATA;
                    end else if (inst_req) begin
                        w_sel_valid = 1'b1;
                        w_sel       = OWN_INST;
                    end
                end
                LOCK_D: begin
                    w_sel_valid = 1'b1;
                    w_sel       = OWN_DATA;
                end
                LOCK_I: begin
                    w_sel_valid = 1'b1;
                    w_sel       = OWN_INST;
                end
                default: begin
                    w_sel_valid = 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        mem_req   = 1'b0;
        mem_wr    = 1'b0;
        mem_size  = 2'd0;
        mem_addr  = 32'd0;
        mem_wstrb = 4'd0;
        mem_wdata = 32'd0;
        if (w_sel_valid) begin
            if (w_sel == OWN_DATA) begin
                mem_req   = data_req;
                mem_wr    = data_wr;
                mem_size  = data_size;
                mem_addr  = data_addr;
                mem_wstrb = data_wstrb;
                mem_wdata = data_wdata;
            end else begin
                mem_req   = inst_req;
                mem_wr    = inst_wr;
                mem_size  = inst_size;
                mem_addr  = inst_addr;
                mem_wstrb = inst_wstrb;
                mem_wdata = inst_wdata;
            end
        end
    end

    assign w_accept     = mem_req & mem_addr_ok;
    assign inst_addr_ok = w_accept & (w_sel == OWN_INST);
    assign data_addr_ok = w_accept & (w_sel == OWN_DATA);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (mem_req && !mem_addr_ok)
                    w_state_nxt = (w_sel == OWN_DATA) ? LOCK_D : LOCK_I;
            end
            LOCK_D, LOCK_I: begin
                if (w_accept)
                    w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_starve <= '0;
        end else if (w_accept && (w_sel == OWN_DATA) && inst_req) begin
            if (!w_starved)
                r_starve <= r_starve + STV_W'(1);
        end else if ((w_accept && (w_sel == OWN_INST)) || !inst_req) begin
            r_starve <= '0;
        end
    end

    arb_order_fifo #(
        .DEPTH (OUTSTANDING)
    ) u_order_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .i_push    (w_accept),
        .i_push_id (w_sel),
        .i_pop     (w_pop),
        .o_full    (w_full),
        .o_empty   (w_empty),
        .o_head    (w_head)
    );

    assign w_pop        = mem_data_ok & ~w_empty;
    assign inst_data_ok = w_pop & (w_head == OWN_INST);
    assign data_data_ok = w_pop & (w_head == OWN_DATA);
    assign inst_rdata   = mem_rdata;
    assign data_rdata   = mem_rdata;

    // A response with nothing outstanding means the slave and arbiter disagree.
    always_ff @(posedge clk) begin
        if (!resetn)
            r_err <= 1'b0;
        else if (mem_data_ok && w_empty)
            r_err <= 1'b1;
    end

    assign arb_err = r_err;

endmodule

`default_nettype wire

// File: tb/tb_sram_like_arbiter.sv
// ============================================================================
// Module      : tb_sram_like_arbiter
// Description : Randomised scoreboard bench for sram_like_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sram_like_arbiter;

    localparam int OUTSTANDING  = 2;
    localparam int STARVE_LIMIT = 4;

    typedef struct packed {
        logic        req;
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } mreq_t;

    typedef struct {
        bit          own;
        logic [31:0] rdata;
    } rsp_t;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    mreq_t       mi = '0;
    mreq_t       md = '0;
    logic        mem_addr_ok = 1'b0;
    logic        mem_data_ok = 1'b0;
    logic [31:0] mem_rdata = 32'd0;

    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic [31:0] inst_rdata, data_rdata;
    logic        mem_req, mem_wr;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        arb_err;

    sram_like_arbiter #(
        .OUTSTANDING  (OUTSTANDING),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .inst_req     (mi.req),
        .inst_wr      (mi.wr),
        .inst_size    (mi.size),
        .inst_addr    (mi.addr),
        .inst_wstrb   (mi.wstrb),
        .inst_wdata   (mi.wdata),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .data_req     (md.req),
        .data_wr      (md.wr),
        .data_size    (md.size),
        .data_addr    (md.addr),
        .data_wstrb   (md.wstrb),
        .data_wdata   (md.wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .mem_req      (mem_req),
        .mem_wr       (mem_wr),
        .mem_size     (mem_size),
        .mem_addr     (mem_addr),
        .mem_wstrb    (mem_wstrb),
        .mem_wdata    (mem_wdata),
        .mem_addr_ok  (mem_addr_ok),
        .mem_data_ok  (mem_data_ok),
        .mem_rdata    (mem_rdata),
        .arb_err      (arb_err)
    );

    // Reference model: owners of accepted-but-unanswered requests in order,
    // the master currently holding the channel (-1 none), starve count, error.
    bit   order_q[$];
    rsp_t sb_q[$];
    int   lock_own = -1;
    int   starve   = 0;
    bit   m_err    = 1'b0;
    bit   drop_i   = 1'b0;
    bit   drop_d   = 1'b0;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic mreq_t new_req();
        mreq_t r;
        r.req   = 1'b1;
        r.wr    = 1'($urandom_range(0, 1));
        r.size  = 2'($urandom_range(0, 2));
        r.addr  = $urandom;
        r.wstrb = 4'($urandom);
        r.wdata = $urandom;
        return r;
    endfunction

    task automatic step(input int p_i, input int p_d, input int p_aok, input int p_rsp,
                        input bit do_rst, input bit force_err);
        int    win;
        bit    exp_req;
        bit    acc;
        mreq_t wm;
        @(negedge clk);
        if (drop_i) mi.req = 1'b0;
        if (drop_d) md.req = 1'b0;
        drop_i = 1'b0;
        drop_d = 1'b0;
        resetn = !do_rst;
        if (!mi.req && $urandom_range(0, 99) < p_i) mi = new_req();
        if (!md.req && $urandom_range(0, 99) < p_d) md = new_req();
        mem_addr_ok = !do_rst && ($urandom_range(0, 99) < p_aok);
        if (force_err)
            mem_data_ok = 1'b1;
        else
            mem_data_ok = !do_rst && (order_q.size() > 0) && ($urandom_range(0, 99) < p_rsp);
        mem_rdata = $urandom;
        #1;
        win = -1;
        if (order_q.size() < OUTSTANDING) begin
            if (lock_own >= 0)
                win = lock_own;
            else if (md.req && !(starve == STARVE_LIMIT && mi.req))
                win = 1;
            else if (mi.req)
                win = 0;
        end
        exp_req = (win >= 0);
        acc     = exp_req && mem_addr_ok;
        chk("mem_req", 96'(mem_req), 96'(exp_req));
        if (exp_req) begin
            wm = (win == 1) ? md : mi;
            chk("mem_fields", 96'({mem_wr, mem_size, mem_addr, mem_wstrb, mem_wdata}),
                96'({wm.wr, wm.size, wm.addr, wm.wstrb, wm.wdata}));
        end
        chk("inst_addr_ok", 96'(inst_addr_ok), 96'(acc && win == 0));
        chk("data_addr_ok", 96'(data_addr_ok), 96'(acc && win == 1));
        chk("arb_err", 96'(arb_err), 96'(m_err));
        if (mem_data_ok && order_q.size() > 0)
            sb_q.push_back('{own: order_q[0], rdata: mem_rdata});
        @(posedge clk);
        if (do_rst) begin
            order_q.delete();
            lock_own = -1;
            starve   = 0;
            m_err    = 1'b0;
        end else begin
            if (mem_data_ok) begin
                if (order_q.size() > 0)
                    void'(order_q.pop_front());
                else
                    m_err = 1'b1;
            end
            if (acc)
                order_q.push_back(win == 1);
            if (acc)
                lock_own = -1;
            else if (exp_req)
                lock_own = win;
            if (acc && win == 1 && mi.req)
                starve = (starve < STARVE_LIMIT) ? starve + 1 : STARVE_LIMIT;
            else if ((acc && win == 0) || !mi.req)
                starve = 0;
            if (acc && win == 0) drop_i = 1'b1;
            if (acc && win == 1) drop_d = 1'b1;
        end
    endtask

    // Response monitor: every data_ok must match the head of the scoreboard.
    initial begin
        rsp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (inst_data_ok || data_data_ok) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rsp_spurious actual=%b%b required=00 t=%0t",
                             inst_data_ok, data_data_ok, $time);
                end else begin
                    e = sb_q.pop_front();
                    chk("rsp_route", 96'({inst_data_ok, data_data_ok}),
                        96'(e.own ? 2'b01 : 2'b10));
                    chk("rsp_rdata", 96'(e.own ? data_rdata : inst_rdata), 96'(e.rdata));
                end
            end else if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                checks++;
                errors++;
                $display("FAIL rsp_missing actual=00 required=%s t=%0t",
                         e.own ? "01" : "10", $time);
            end
        end
    end

    initial begin
        repeat (2) step(0, 0, 0, 0, 1'b1, 1'b0);
        repeat (300) step(40, 40, 60, 50, 1'b0, 1'b0);
        repeat (200) step(100, 100, 100, 100, 1'b0, 1'b0);
        repeat (200) step(70, 70, 30, 20, 1'b0, 1'b0);
        repeat (30) step(100, 100, 100, 0, 1'b0, 1'b0);
        step(0, 0, 0, 0, 1'b1, 1'b0);
        step(0, 0, 0, 0, 1'b0, 1'b1);
        repeat (50) step(50, 50, 60, 50, 1'b0, 1'b0);
        repeat (2) step(0, 0, 0, 0, 1'b1, 1'b0);
        repeat (200) step(60, 60, 50, 40, 1'b0, 1'b0);
        repeat (40) step(0, 0, 100, 100, 1'b0, 1'b0);
        @(negedge clk);
        #3;
        chk("sb_drain", 96'(sb_q.size()), 96'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
